linear_layer_start_sync_fifo: RTL

- Control and storage wrapper for the start-token FIFOs between dataflow processes in the i4xi4 linear layer, e.g. the producer and the `PE_i4xi4_pack_2x2` consumer.
- Manages occupancy and the full/empty handshakes.
- Drives write-enable and read address into a shift-register (SRL) storage sub-module; oldest entry is read combinationally.
- Sits between the producer's start/done signalling and the consumer's ap_start, so downstream PEs start only when a token is queued.

---
 rtl/linear_layer_start_sync_fifo_srl.sv | 36 +++
 rtl/linear_layer_start_sync_fifo.sv | 87 ++++++++
 2 files changed

// File: rtl/linear_layer_start_sync_fifo_srl.sv
// Shift-register token storage: newest entry at index 0, read port addressed combinationally.
// Contents are deliberately not reset; the controller's flags qualify dout.
module linear_layer_start_sync_fifo_srl #(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned ADDR_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int unsigned SRL_DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [SRL_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [SRL_DEPTH];

    // Shift older entries up one slot and load the new token at index 0.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            for (int i = SRL_DEPTH - 1; i > 0; i--) begin
                mem_d[i] = mem_q[i-1];
            end
            mem_d[0] = din;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout = mem_q[addr];

endmodule

// File: rtl/linear_layer_start_sync_fifo.sv
// Start-token FIFO controller: occupancy, registered full/empty handshakes and SRL addressing.
// Downstream ap_start is gated by if_empty_n, so consumers only start when a token is queued.
module linear_layer_start_sync_fifo #(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned ADDR_WIDTH = 1,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_empty_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic [ADDR_WIDTH:0]   if_num_data_valid,
    output logic [ADDR_WIDTH:0]   if_fifo_cap
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full_n_q, full_n_d;
    logic                  empty_n_q, empty_n_d;
    logic                  push_c, pop_c;
    logic [ADDR_WIDTH-1:0] addr_c;

    // Requests are only honoured against the registered flags, so a full FIFO
    // refuses a write even when a pop happens in the same cycle.
    assign push_c = if_write & if_write_ce & full_n_q;
    assign pop_c  = if_read  & if_read_ce  & empty_n_q;

    always_comb begin
        addr_c = '0;
        if (count_q != '0) begin
            addr_c = ADDR_WIDTH'(count_q - ONE_C);
        end
    end

    always_comb begin
        count_d   = count_q;
        full_n_d  = full_n_q;
        empty_n_d = empty_n_q;
        if (push_c && !pop_c) begin
            count_d   = count_q + ONE_C;
            empty_n_d = 1'b1;
            full_n_d  = ((count_q + ONE_C) != DEPTH_C);
        end else if (pop_c && !push_c) begin
            count_d   = count_q - ONE_C;
            full_n_d  = 1'b1;
            empty_n_d = ((count_q - ONE_C) != '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            full_n_q  <= 1'b1;
            empty_n_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            full_n_q  <= full_n_d;
            empty_n_q <= empty_n_d;
        end
    end

    linear_layer_start_sync_fifo_srl #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_srl (
        .clk  (clk),
        .we   (push_c),
        .addr (addr_c),
        .din  (if_din),
        .dout (if_dout)
    );

    assign if_full_n         = full_n_q;
    assign if_empty_n        = empty_n_q;
    assign if_num_data_valid = count_q;
    assign if_fifo_cap       = DEPTH_C;

endmodule
